// File: rtl/main_memory.sv
// main_memory: 128-bit line memory with a fixed access latency, serving one request at a time.
module main_memory #(
    parameter int LATENCY    = 10,
    parameter int INDEX_BITS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_Mem,
    input  logic         write_Mem,
    input  logic [31:0]  Addr_Mem,
    input  logic [127:0] Data_Mem_write,
    output logic [127:0] Data_Mem_read,
    output logic         ready_mem,
    output logic [31:0]  access_count
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t                state;
    logic [7:0]            cnt;
    logic                  op_wr;
    logic [INDEX_BITS-1:0] idx;
    logic [127:0]          wdata;
    logic [127:0]          mem [2**INDEX_BITS];
    logic                  fire;
    logic                  unused_addr;
    assign unused_addr = ^{Addr_Mem[31:INDEX_BITS+4], Addr_Mem[3:0]};
    assign fire = (state == BUSY) && (cnt == 8'd1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            ready_mem     <= 1'b1;
            Data_Mem_read <= '0;
            cnt           <= '0;
            access_count  <= '0;
        end else begin
            case (state)
                IDLE: if (read_Mem || write_Mem) begin
                    op_wr     <= write_Mem;
                    idx       <= Addr_Mem[INDEX_BITS+3:4];
                    wdata     <= Data_Mem_write;
                    cnt       <= 8'(LATENCY);
                    ready_mem <= 1'b0;
                    state     <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (fire) begin
                        if (!op_wr) Data_Mem_read <= mem[idx];
                        access_count <= access_count + 32'd1;
                        ready_mem    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: if (!read_Mem && !write_Mem) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // Array has no reset; a write aborted by reset never commits.
    always_ff @(posedge clk) begin
        if (reset && fire && op_wr) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed scoreboard bench for main_memory.
module tb_main_memory;
    localparam int LAT = 10;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         read_Mem = 1'b0, write_Mem = 1'b0;
    logic [31:0]  Addr_Mem = '0;
    logic [127:0] Data_Mem_write = '0;
    logic [127:0] Data_Mem_read;
    logic         ready_mem;
    logic [31:0]  access_count;
    int           checks = 0, errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model [int];
    logic [127:0] last_read = '0;
    logic [31:0]  exp_cnt = '0;

    main_memory #(.LATENCY(LAT), .INDEX_BITS(10)) dut (
        .clk(clk), .reset(reset), .read_Mem(read_Mem), .write_Mem(write_Mem),
        .Addr_Mem(Addr_Mem), .Data_Mem_write(Data_Mem_write),
        .Data_Mem_read(Data_Mem_read), .ready_mem(ready_mem), .access_count(access_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [127:0] d, input int hold);
        int n = 0;
        int key = int'(a[13:4]);
        logic [127:0] e;
        @(negedge clk);
        read_Mem = rd; write_Mem = wr; Addr_Mem = a; Data_Mem_write = d;
        if (rd && !wr) exp_q.push_back(model.exists(key) ? model[key] : 'x);
        @(negedge clk);
        while (!ready_mem && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("latency", 128'(n), 128'(LAT));
        exp_cnt++;
        if (wr) begin
            model[key] = d;
            e = last_read;
        end else begin
            e = exp_q.pop_front();
            last_read = e;
        end
        check(wr ? "write_data_hold" : "read_data", Data_Mem_read, e);
        check("count", 128'(access_count), 128'(exp_cnt));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_ready", 128'(ready_mem), 128'd1);
            check("held_count", 128'(access_count), 128'(exp_cnt));
        end
        read_Mem = 1'b0; write_Mem = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 128'(ready_mem), 128'd1);
        check("rst_data", Data_Mem_read, 128'd0);
        check("rst_count", 128'(access_count), 128'd0);
        reset = 1'b1;
        access(1'b0, 1'b1, 32'h40, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 0);
        access(1'b1, 1'b0, 32'h40, '0, 5);
        access(1'b1, 1'b0, 32'h404C, '0, 0);
        access(1'b1, 1'b1, 32'h80, 128'h1, 0);
        access(1'b1, 1'b0, 32'h80, '0, 0);
        access(1'b0, 1'b1, 32'h100, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 0);
        access(1'b1, 1'b0, 32'h100, '0, 0);
        // Abort a write to 0x100 mid-flight; the old line must survive.
        @(negedge clk);
        write_Mem = 1'b1; Addr_Mem = 32'h100; Data_Mem_write = 128'hBAD;
        repeat (5) @(negedge clk);
        check("abort_busy", 128'(ready_mem), 128'd0);
        reset = 1'b0; write_Mem = 1'b0;
        @(negedge clk);
        check("abort_ready", 128'(ready_mem), 128'd1);
        check("abort_count", 128'(access_count), 128'd0);
        check("abort_data", Data_Mem_read, 128'd0);
        reset = 1'b1;
        exp_cnt = '0;
        last_read = '0;
        access(1'b1, 1'b0, 32'h100, '0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_memory.md
# main_memory

Line-oriented main-memory model with fixed, parameterised access latency, sitting directly downstream of the cache controller arbiter. It receives one 128-bit line request at a time on the arbiter's memory port (read_Mem / write_Mem / Addr_Mem / Data_Mem_write), holds ready_mem low while the access is in flight, and raises ready_mem with the line on Data_Mem_read when done. Both caches see this latency through the arbiter.

## Interface
Parameters:
- LATENCY, 10: cycles ready_mem stays low per access; legal range 1..255.
- INDEX_BITS, 10: line-index width; array holds 2^INDEX_BITS lines of 128 bits.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge.
- read_Mem  input  1  line read request, level, held until completion.
- write_Mem  input  1  line write request, level, held until completion.
- Addr_Mem  input  32  byte address; line index = Addr_Mem[INDEX_BITS+3:4].
- Data_Mem_write  input  128  write line data.
- Data_Mem_read  output  128  read line data; valid while ready_mem=1 after a read.
- ready_mem  output  1  1 = idle or completed, 0 = access in flight.
- access_count  output  32  number of completed accesses (reads + writes), wraps.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: ready_mem=1. If read_Mem or write_Mem sampled high: latch op, index, write data; load counter with LATENCY; go BUSY.
- Both read_Mem and write_Mem high: treated as write; no read performed.
- BUSY: ready_mem=0; counter decrements each cycle; inputs ignored (latched copies used). On the edge where counter==1: perform access, go DONE.
  - Read: Data_Mem_read <= array[index].
  - Write: array[index] <= latched data; Data_Mem_read unchanged.
  - access_count increments by 1 (mod 2^32).
- DONE: ready_mem=1. Stay while read_Mem or write_Mem high (no re-trigger of a held level request). Both low sampled -> IDLE.
- Address bits [3:0] and bits above INDEX_BITS+3 ignored; indices alias modulo 2^INDEX_BITS.
- Reset (reset=0 at edge): state IDLE, ready_mem=1, Data_Mem_read=0, counter=0, access_count=0. Array contents not cleared.
- Reset mid-BUSY: access aborted; pending write never committed, access_count not incremented.

## Timing
- Request sampled high in IDLE at edge E: ready_mem low after E through E+LATENCY; access and ready_mem=1 registered at edge E+LATENCY.
- Read data valid from edge E+LATENCY, stable until next completed read or reset.
- DONE -> IDLE costs one cycle after requester drops both requests; earliest next accept is the edge after IDLE is entered (minimum 1 idle cycle between accesses).
- Request changes during BUSY have no effect; a request dropped mid-BUSY still completes.
- Write followed by read of same index returns the newly written line (no hazard; accesses are serialised).

## Test plan
- Reset: drive reset=0 two cycles -> ready_mem=1, Data_Mem_read=0, access_count=0, state IDLE.
- Write/read, LATENCY=10: write 128'hDEAD..BEEF to Addr 0x40, ready_mem low exactly 10 cycles; drop; read 0x40 -> after 10 cycles ready_mem=1, Data_Mem_read=128'hDEAD..BEEF, access_count=2.
- Held request: keep read_Mem high 5 cycles after ready_mem rises -> no second access, access_count unchanged, ready_mem stays 1.
- Aliasing/offset: write line to 0x0000_0040, read 0x0000_404C (INDEX_BITS=10) -> same line returned.
- Simultaneous read+write at 0x80 with data 128'h1 -> line written, Data_Mem_read unchanged; later read 0x80 returns 128'h1.
- Reset mid-write: assert reset=0 at cycle 5 of a write to 0x100 -> ready_mem=1 next cycle, subsequent read of 0x100 returns prior contents, access_count=0.
